weight_loader: RTL and testbench

//  Upstream sequencer for the 25-entry 5x5 conv-kernel weight register bank.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/weight_loader.sv | 122 ++++++++++++
 tb/tb_weight_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and loader FSM state type for the 5x5 conv-kernel weight bank.
// WEIGHT_LOADER_CSUM_EN adds the checksum state CHK to the state type.
package cnn_pkg;

  localparam int N_WEIGHTS   = 25;
  localparam int WEIGHT_W    = 8;
  localparam int BANK_ADDR_W = 5;
  localparam int COUNT_W     = $clog2(N_WEIGHTS + 1);

  // Bank is 1-based; address 0 is never written.
  localparam logic [BANK_ADDR_W-1:0] ADDR_BASE = BANK_ADDR_W'(1);
  localparam logic [COUNT_W-1:0]     LAST_IDX  = COUNT_W'(N_WEIGHTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
`ifdef WEIGHT_LOADER_CSUM_EN
    CHK  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/weight_loader.sv
// Turns a valid/ready weight byte stream into 25 single-cycle writes to the kernel bank.
// WEIGHT_LOADER_CSUM_EN: trailing checksum byte compared against the mod-256 weight sum.
module weight_loader
  import cnn_pkg::*;
(
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iStart,
  input  logic                   iAbort,
  input  logic [WEIGHT_W-1:0]    iData,
  input  logic                   iValid,
  output logic                   oReady,
  output logic                   oWren,
  output logic [BANK_ADDR_W-1:0] oAddr,
  output logic [WEIGHT_W-1:0]    oWeight,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oErr,
  output state_t                 oState
);

  // Handshake: a byte transfers on a rising edge where iValid && oReady && !iAbort.
  // oReady depends on state only, never on iValid.

  state_t                 r_state;
  state_t                 w_next;
  logic [COUNT_W-1:0]     r_count;
  logic                   r_wren;
  logic [BANK_ADDR_W-1:0] r_addr;
  logic [WEIGHT_W-1:0]    r_weight;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_wr;

`ifdef WEIGHT_LOADER_CSUM_EN
  logic [7:0] r_sum;
  logic       r_err;
  logic       w_chk_accept;
`endif

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      IDLE: if (iStart) w_next = LOAD;
      LOAD: begin
        w_ready = 1'b1;
        if (iAbort) w_next = IDLE;
        else if (iValid && r_count == LAST_IDX) begin
`ifdef WEIGHT_LOADER_CSUM_EN
          w_next = CHK;
`else
          w_next = DONE;
`endif
        end
      end
`ifdef WEIGHT_LOADER_CSUM_EN
      CHK: begin
        w_ready = 1'b1;
        if (iAbort) w_next = IDLE;
        else if (iValid) w_next = DONE;
      end
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Abort wins over a same-cycle beat: the byte is dropped.
  assign w_accept = w_ready && iValid && !iAbort;
  assign w_wr     = w_accept && (r_state == LOAD);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_wren   <= 1'b0;
      r_addr   <= '0;
      r_weight <= '0;
    end else begin
      r_state <= w_next;
      r_wren  <= w_wr;
      if (r_state == IDLE && iStart) begin
        r_count <= '0;
      end else if (w_wr) begin
        r_addr   <= ADDR_BASE + BANK_ADDR_W'(r_count);
        r_weight <= iData;
        r_count  <= r_count + 1'b1;
      end
    end
  end

`ifdef WEIGHT_LOADER_CSUM_EN
  assign w_chk_accept = w_accept && (r_state == CHK);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (r_state == IDLE && iStart) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_wr) r_sum <= r_sum + iData;
      if (w_chk_accept) r_err <= (iData != r_sum);
    end
  end

  assign oErr = r_err;
`else
  assign oErr = 1'b0;
`endif

  assign oReady  = w_ready;
  assign oWren   = r_wren;
  assign oAddr   = r_addr;
  assign oWeight = r_weight;
  assign oBusy   = (r_state != IDLE);
  assign oDone   = (r_state == DONE);
  assign oState  = r_state;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: scoreboard of expected bank writes, directed load scenarios.
// Define WEIGHT_LOADER_CSUM_EN for both bench and RTL to exercise the checksum path.
module tb_weight_loader;
  import cnn_pkg::*;

  logic                   iCLK = 1'b0;
  logic                   iRST;
  logic                   iStart;
  logic                   iAbort;
  logic [WEIGHT_W-1:0]    iData;
  logic                   iValid;
  logic                   oReady;
  logic                   oWren;
  logic [BANK_ADDR_W-1:0] oAddr;
  logic [WEIGHT_W-1:0]    oWeight;
  logic                   oBusy;
  logic                   oDone;
  logic                   oErr;
  state_t                 oState;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int n_dones  = 0;

  logic [BANK_ADDR_W+WEIGHT_W-1:0] exp_q[$];
  logic [BANK_ADDR_W-1:0]          exp_addr;
  logic [7:0]                      csum;

  weight_loader dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iAbort(iAbort),
    .iData(iData), .iValid(iValid), .oReady(oReady), .oWren(oWren),
    .oAddr(oAddr), .oWeight(oWeight), .oBusy(oBusy), .oDone(oDone),
    .oErr(oErr), .oState(oState)
  );

  // ---------------- clock / watchdog ----------------
  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge iCLK) begin
    if (oDone) n_dones++;
    if (oWren) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {19'd0, oAddr, oWeight}, 32'd0);
      end else begin
        logic [BANK_ADDR_W+WEIGHT_W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(oAddr), 32'(e[BANK_ADDR_W+WEIGHT_W-1:WEIGHT_W]));
        check("wr_weight", 32'(oWeight), 32'(e[WEIGHT_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_start();
    iStart = 1'b1;
    tick();
    iStart   = 1'b0;
    exp_addr = BANK_ADDR_W'(1);
    csum     = 8'd0;
  endtask

  task automatic send_weight(input logic [WEIGHT_W-1:0] d);
    iValid = 1'b1;
    iData  = d;
    exp_q.push_back({exp_addr, d});
    exp_addr = exp_addr + 1'b1;
    csum     = csum + d;
    tick();
    iValid = 1'b0;
  endtask

  task automatic idle_cycle();
    iValid = 1'b0;
    iData  = WEIGHT_W'($urandom_range(0, 255));
    tick();
  endtask

  task automatic send_csum(input logic [7:0] d);
    iValid = 1'b1;
    iData  = d;
    tick();
    iValid = 1'b0;
  endtask

  // Called right after the last weight: DONE must be showing now.
  task automatic end_load(input string tag);
`ifdef WEIGHT_LOADER_CSUM_EN
    send_csum(csum);
    check({tag, "_err"}, 32'(oErr), 32'd0);
`else
    check({tag, "_done_wren"}, 32'(oWren), 32'd1);
    check({tag, "_done_addr"}, 32'(oAddr), 32'd25);
`endif
    check({tag, "_done"}, 32'(oDone), 32'd1);
    tick();
    check({tag, "_done_pulse"}, 32'(oDone), 32'd0);
    check({tag, "_busy_after"}, 32'(oBusy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wren"}, 32'(oWren), 32'd0);
    check({tag, "_addr"}, 32'(oAddr), 32'd0);
    check({tag, "_weight"}, 32'(oWeight), 32'd0);
    check({tag, "_ready"}, 32'(oReady), 32'd0);
    check({tag, "_busy"}, 32'(oBusy), 32'd0);
    check({tag, "_done"}, 32'(oDone), 32'd0);
    check({tag, "_err"}, 32'(oErr), 32'd0);
    check({tag, "_state"}, 32'(oState), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    int d0;
    iRST = 1'b1; iStart = 1'b0; iAbort = 1'b0; iValid = 1'b0; iData = '0;
    exp_addr = BANK_ADDR_W'(1); csum = 8'd0;
    repeat (3) tick();
    check_all_zero("reset");
    iRST = 1'b0;
    tick();

    // 1: back-to-back load of 1..25
    w0 = n_writes; d0 = n_dones;
    do_start();
    check("t1_ready", 32'(oReady), 32'd1);
    check("t1_busy", 32'(oBusy), 32'd1);
    for (int i = 1; i <= N_WEIGHTS; i++) send_weight(WEIGHT_W'(i));
    end_load("t1");
    check("t1_writes", 32'(n_writes - w0), 32'd25);
    check("t1_dones", 32'(n_dones - d0), 32'd1);

    // 2: iValid toggling, random weights
    w0 = n_writes;
    do_start();
    for (int i = 1; i <= N_WEIGHTS; i++) begin
      send_weight(WEIGHT_W'($urandom_range(0, 255)));
      if (i != N_WEIGHTS) idle_cycle();
    end
    end_load("t2");
    check("t2_writes", 32'(n_writes - w0), 32'd25);

    // 3: valid data while idle, no start
    w0 = n_writes;
    iValid = 1'b1; iData = 8'h7F;
    repeat (4) begin
      tick();
      check("t3_ready", 32'(oReady), 32'd0);
      check("t3_busy", 32'(oBusy), 32'd0);
    end
    iValid = 1'b0;
    tick();
    check("t3_writes", 32'(n_writes - w0), 32'd0);

    // 4: abort after 10 beats; the same-cycle beat is dropped
    w0 = n_writes; d0 = n_dones;
    do_start();
    for (int i = 1; i <= 10; i++) send_weight(WEIGHT_W'(8'h80 + i));
    iAbort = 1'b1; iValid = 1'b1; iData = 8'h55;
    tick();
    iAbort = 1'b0; iValid = 1'b0;
    check("t4_busy", 32'(oBusy), 32'd0);
    check("t4_ready", 32'(oReady), 32'd0);
    check("t4_state", 32'(oState), 32'(IDLE));
    tick();
    check("t4_wren", 32'(oWren), 32'd0);
    check("t4_writes", 32'(n_writes - w0), 32'd10);
    check("t4_no_done", 32'(n_dones - d0), 32'd0);
    do_start();
    for (int i = 1; i <= N_WEIGHTS; i++) send_weight(WEIGHT_W'(8'hF0 - i));
    end_load("t4b");

    // 5: reset at beat 12
    w0 = n_writes;
    do_start();
    for (int i = 1; i <= 11; i++) send_weight(WEIGHT_W'(i * 3));
    iRST = 1'b1; iValid = 1'b1; iData = 8'd36;
    tick();
    check_all_zero("t5_rst");
    iRST = 1'b0; iValid = 1'b0;
    tick();
    check("t5_writes", 32'(n_writes - w0), 32'd11);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);
    do_start();
    for (int i = 1; i <= N_WEIGHTS; i++) send_weight(WEIGHT_W'(8'h40 + i));
    end_load("t5b");

`ifdef WEIGHT_LOADER_CSUM_EN
    // 6: checksum 25 x 0x0B = 0x113 -> 0x13
    do_start();
    for (int i = 1; i <= N_WEIGHTS; i++) send_weight(8'h0B);
    check("t6_ready_chk", 32'(oReady), 32'd1);
    send_csum(8'h13);
    check("t6_good_err", 32'(oErr), 32'd0);
    check("t6_good_done", 32'(oDone), 32'd1);
    tick();
    do_start();
    for (int i = 1; i <= N_WEIGHTS; i++) send_weight(8'h0B);
    send_csum(8'h14);
    check("t6_bad_err", 32'(oErr), 32'd1);
    check("t6_bad_done", 32'(oDone), 32'd1);
    repeat (3) tick();
    check("t6_err_held", 32'(oErr), 32'd1);
    do_start();
    check("t6_err_clr", 32'(oErr), 32'd0);
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    check("t6_abort_idle", 32'(oBusy), 32'd0);
`endif

    repeat (2) tick();
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
